// File: rtl/ram_port_arbiter_if.sv
// Bundle of every handshake and bus signal around one RAM-port arbiter:
// the NUM_REQ command/response side and the single RAM port side.
// "master" is the arbiter's view, "slave" is the view of the environment
// (requesters plus RAM) that drives the arbiter.
interface ram_port_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int BUS_WIDTH  = 64
);
    localparam int ID_W = $clog2(NUM_REQ);

    // Requester command side
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*BUS_WIDTH-1:0]  req_wdata;

    // Response side
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [ID_W-1:0]               rsp_id;
    logic [BUS_WIDTH-1:0]          rsp_rdata;
    logic                          rsp_err;

    // RAM port side
    logic                          ram_addr_valid;
    logic                          ram_addr_ready;
    logic [ADDR_WIDTH-1:0]         ram_addr;
    logic                          ram_we;
    logic                          ram_wvalid;
    logic                          ram_wready;
    logic [BUS_WIDTH-1:0]          ram_wdata;
    logic                          ram_rvalid;
    logic                          ram_rready;
    logic [BUS_WIDTH-1:0]          ram_rdata;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_id, rsp_rdata, rsp_err,
        input  rsp_ready,
        output ram_addr_valid, ram_addr, ram_we, ram_wvalid, ram_wdata, ram_rready,
        input  ram_addr_ready, ram_wready, ram_rvalid, ram_rdata
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_id, rsp_rdata, rsp_err,
        output rsp_ready,
        input  ram_addr_valid, ram_addr, ram_we, ram_wvalid, ram_wdata, ram_rready,
        output ram_addr_ready, ram_wready, ram_rvalid, ram_rdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between NUM_REQ requesters.
// One command is in flight at a time: IDLE grants, ADDR runs the address
// (and, for writes, write-data) handshakes, RDATA waits for read data,
// RESP presents the tagged response. A watchdog turns a stalled RAM
// transaction into an error response.
module ram_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int BUS_WIDTH  = 64,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                rst,
    ram_port_arbiter_if.master  bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Counter value during the TIMEOUT-th waiting cycle
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_RDATA = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                 state_q;
    logic [ID_W-1:0]        ptr_q;
    logic [CNT_W-1:0]       wd_cnt_q;
    logic                   addr_done_q;
    logic                   wdata_done_q;

    // Registered outputs
    logic                   rsp_valid_q;
    logic [ID_W-1:0]        rsp_id_q;
    logic [BUS_WIDTH-1:0]   rsp_rdata_q;
    logic                   rsp_err_q;
    logic                   ram_addr_valid_q;
    logic [ADDR_WIDTH-1:0]  ram_addr_q;
    logic                   ram_we_q;
    logic                   ram_wvalid_q;
    logic [BUS_WIDTH-1:0]   ram_wdata_q;
    logic                   ram_rready_q;

    // Per-requester views of the packed command buses
    logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_REQ];
    logic [BUS_WIDTH-1:0]   wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0]     upper_mask;
    logic [NUM_REQ-1:0]     upper_req;
    logic [NUM_REQ-1:0]     req_ready_d;

    // Arbitration results
    logic [NUM_REQ-1:0]     pick_vec;
    logic [ID_W-1:0]        grant_idx;
    logic                   grant_any;
    logic                   grant_en;

    // Handshake bookkeeping for the current cycle
    logic                   addr_hs;
    logic                   wdata_hs;
    logic                   addr_done_d;
    logic                   wdata_done_d;
    logic                   timeout_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign addr_arr[gi]   = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi]  = bus.req_wdata[gi*BUS_WIDTH +: BUS_WIDTH];
            // Requesters strictly above the last winner get first look
            assign upper_mask[gi] = (ID_W'(gi) > ptr_q);
            assign req_ready_d[gi] = grant_en && (grant_idx == ID_W'(gi));
        end
    endgenerate

    assign upper_req = bus.req_valid & upper_mask;

    // Round-robin pick: lowest requester above ptr, else wrap to the lowest overall
    always_comb begin
        grant_any = |bus.req_valid;
        pick_vec  = (|upper_req) ? upper_req : bus.req_valid;
        grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (pick_vec[k]) begin
                grant_idx = ID_W'(k);
            end
        end
    end

    // A grant is only offered while idle and never while reset is asserted
    assign grant_en = (state_q == S_IDLE) && grant_any && !rst;

    // RAM handshake completion and watchdog expiry for this cycle
    always_comb begin
        addr_hs      = ram_addr_valid_q && bus.ram_addr_ready;
        wdata_hs     = ram_wvalid_q && bus.ram_wready;
        addr_done_d  = addr_done_q || addr_hs;
        wdata_done_d = wdata_done_q || wdata_hs;
        timeout_hit  = (wd_cnt_q >= CNT_LAST);
    end

    // Transaction sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            ptr_q            <= ID_W'(NUM_REQ - 1);
            wd_cnt_q         <= '0;
            addr_done_q      <= 1'b0;
            wdata_done_q     <= 1'b0;
            rsp_valid_q      <= 1'b0;
            rsp_id_q         <= '0;
            rsp_rdata_q      <= '0;
            rsp_err_q        <= 1'b0;
            ram_addr_valid_q <= 1'b0;
            ram_addr_q       <= '0;
            ram_we_q         <= 1'b0;
            ram_wvalid_q     <= 1'b0;
            ram_wdata_q      <= '0;
            ram_rready_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_any) begin
                        ptr_q            <= grant_idx;
                        rsp_id_q         <= grant_idx;
                        ram_addr_q       <= addr_arr[grant_idx];
                        ram_wdata_q      <= wdata_arr[grant_idx];
                        ram_we_q         <= bus.req_we[grant_idx];
                        ram_addr_valid_q <= 1'b1;
                        ram_wvalid_q     <= bus.req_we[grant_idx];
                        addr_done_q      <= 1'b0;
                        // Reads have no write-data handshake, so it starts out done
                        wdata_done_q     <= !bus.req_we[grant_idx];
                        wd_cnt_q         <= '0;
                        rsp_rdata_q      <= '0;
                        rsp_err_q        <= 1'b0;
                        state_q          <= S_ADDR;
                    end
                end

                S_ADDR: begin
                    addr_done_q      <= addr_done_d;
                    wdata_done_q     <= wdata_done_d;
                    ram_addr_valid_q <= ram_addr_valid_q && !addr_hs;
                    ram_wvalid_q     <= ram_wvalid_q && !wdata_hs;
                    if (!timeout_hit) begin
                        wd_cnt_q <= wd_cnt_q + CNT_W'(1);
                    end
                    // Completion wins over a simultaneous timeout
                    if (addr_done_d && wdata_done_d) begin
                        if (ram_we_q) begin
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end else begin
                            ram_rready_q <= 1'b1;
                            state_q      <= S_RDATA;
                        end
                    end else if (timeout_hit) begin
                        ram_addr_valid_q <= 1'b0;
                        ram_wvalid_q     <= 1'b0;
                        rsp_err_q        <= 1'b1;
                        rsp_rdata_q      <= '0;
                        rsp_valid_q      <= 1'b1;
                        state_q          <= S_RESP;
                    end
                end

                S_RDATA: begin
                    if (!timeout_hit) begin
                        wd_cnt_q <= wd_cnt_q + CNT_W'(1);
                    end
                    if (bus.ram_rvalid) begin
                        rsp_rdata_q  <= bus.ram_rdata;
                        ram_rready_q <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end else if (timeout_hit) begin
                        ram_rready_q <= 1'b0;
                        rsp_err_q    <= 1'b1;
                        rsp_rdata_q  <= '0;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end
                end

                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ram_we_q    <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready      = req_ready_d;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_id         = rsp_id_q;
    assign bus.rsp_rdata      = rsp_rdata_q;
    assign bus.rsp_err        = rsp_err_q;
    assign bus.ram_addr_valid = ram_addr_valid_q;
    assign bus.ram_addr       = ram_addr_q;
    assign bus.ram_we         = ram_we_q;
    assign bus.ram_wvalid     = ram_wvalid_q;
    assign bus.ram_wdata      = ram_wdata_q;
    assign bus.ram_rready     = ram_rready_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: a transaction-level model
// predicts every output each cycle; directed sequences add hand-computed
// expectations, followed by a long randomized run.
module tb_ram_port_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int ADDR_WIDTH = 32;
    localparam int BUS_WIDTH  = 64;
    localparam int TIMEOUT    = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(
        .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .BUS_WIDTH(BUS_WIDTH)
    ) bus ();

    ram_port_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH),
        .BUS_WIDTH(BUS_WIDTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // ---------------- transaction-level model ----------------
    // phase: 0 waiting for a command, 1 sending address/data, 2 waiting for
    // read data, 3 presenting the response
    int                    m_phase;
    int                    m_ptr;
    int                    m_id;
    bit                    m_we;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [BUS_WIDTH-1:0]  m_wdata;
    bit                    m_need_addr;
    bit                    m_need_data;
    int                    m_spent;
    logic [BUS_WIDTH-1:0]  m_rdata;
    bit                    m_err;
    bit                    m_fresh;

    function automatic int rr_pick(input int ptr, input logic [NUM_REQ-1:0] v);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_ptr = NUM_REQ - 1; m_id = 0; m_we = 0;
        m_addr = '0; m_wdata = '0; m_need_addr = 0; m_need_data = 0;
        m_spent = 0; m_rdata = '0; m_err = 0; m_fresh = 1;
    endtask

    task automatic check_outputs();
        logic [NUM_REQ-1:0] exp_ready;
        int w;
        exp_ready = '0;
        if (!rst && m_phase == 0) begin
            w = rr_pick(m_ptr, bus.req_valid);
            if (w >= 0) exp_ready[w] = 1'b1;
        end
        chk("req_ready", bus.req_ready, exp_ready);
        chk("rsp_valid", bus.rsp_valid, m_phase == 3);
        chk("ram_addr_valid", bus.ram_addr_valid, m_phase == 1 && m_need_addr);
        chk("ram_wvalid", bus.ram_wvalid, m_phase == 1 && m_need_data);
        chk("ram_rready", bus.ram_rready, m_phase == 2);
        if (m_phase == 3) begin
            chk("rsp_id", bus.rsp_id, m_id);
            chk("rsp_rdata", bus.rsp_rdata, m_rdata);
            chk("rsp_err", bus.rsp_err, m_err);
        end
        if (m_phase == 1 && m_need_addr) begin
            chk("ram_addr", bus.ram_addr, m_addr);
            chk("ram_we", bus.ram_we, m_we);
        end
        if (m_phase == 1 && m_need_data) chk("ram_wdata", bus.ram_wdata, m_wdata);
        if (m_fresh) begin
            chk("reset rsp_id", bus.rsp_id, 0);
            chk("reset rsp_rdata", bus.rsp_rdata, 0);
            chk("reset rsp_err", bus.rsp_err, 0);
            chk("reset ram_addr", bus.ram_addr, 0);
            chk("reset ram_we", bus.ram_we, 0);
            chk("reset ram_wdata", bus.ram_wdata, 0);
        end
    endtask

    task automatic model_step();
        int w;
        if (rst) begin
            model_reset();
            return;
        end
        case (m_phase)
            0: begin
                w = rr_pick(m_ptr, bus.req_valid);
                if (w >= 0) begin
                    m_ptr = w; m_id = w; m_we = bus.req_we[w];
                    m_addr  = bus.req_addr[w*ADDR_WIDTH +: ADDR_WIDTH];
                    m_wdata = bus.req_wdata[w*BUS_WIDTH +: BUS_WIDTH];
                    m_need_addr = 1; m_need_data = m_we;
                    m_spent = 0; m_rdata = '0; m_err = 0; m_fresh = 0;
                    m_phase = 1;
                end
            end
            1: begin
                m_spent++;
                if (m_need_addr && bus.ram_addr_ready) m_need_addr = 0;
                if (m_need_data && bus.ram_wready) m_need_data = 0;
                if (!m_need_addr && !m_need_data) m_phase = m_we ? 3 : 2;
                else if (m_spent >= TIMEOUT) begin
                    m_need_addr = 0; m_need_data = 0;
                    m_err = 1; m_rdata = '0; m_phase = 3;
                end
            end
            2: begin
                m_spent++;
                if (bus.ram_rvalid) begin
                    m_rdata = bus.ram_rdata; m_phase = 3;
                end else if (m_spent >= TIMEOUT) begin
                    m_err = 1; m_rdata = '0; m_phase = 3;
                end
            end
            default: begin
                if (bus.rsp_ready) m_phase = 0;
            end
        endcase
    endtask

    // Called at a falling edge with inputs already set: compare, advance the
    // model over the coming rising edge, and return at the next falling edge.
    task automatic cycle();
        #1;
        check_outputs();
        model_step();
        @(negedge clk);
    endtask

    task automatic set_idle_inputs();
        bus.req_valid = '0; bus.req_we = '0;
        bus.req_addr = '0; bus.req_wdata = '0;
        bus.ram_addr_ready = 1'b0; bus.ram_wready = 1'b0;
        bus.ram_rvalid = 1'b0; bus.ram_rdata = '0;
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    int grants[$];
    int widx;
    int seen;

    initial begin
        rst = 1'b1;
        set_idle_inputs();
        @(negedge clk);
        @(negedge clk);
        model_reset();
        cycle();               // reset state compared while rst is still high
        rst = 1'b0;

        // ---- single read from requester 2 ----
        bus.req_valid = 4'b0100;
        bus.req_addr[2*ADDR_WIDTH +: ADDR_WIDTH] = 32'h2000;
        bus.ram_addr_ready = 1'b1; bus.ram_wready = 1'b1;
        #1 chk("read req_ready c0", bus.req_ready, 4'b0100);
        cycle();
        bus.req_valid = '0;
        chk("read ram_addr c1", bus.ram_addr, 32'h2000);
        chk("read ram_addr_valid c1", bus.ram_addr_valid, 1);
        cycle();
        bus.ram_rvalid = 1'b1; bus.ram_rdata = 64'hDEAD_BEEF;
        cycle();
        bus.ram_rvalid = 1'b0;
        chk("read rsp_valid c3", bus.rsp_valid, 1);
        chk("read rsp_id c3", bus.rsp_id, 2);
        chk("read rsp_rdata c3", bus.rsp_rdata, 64'hDEAD_BEEF);
        chk("read rsp_err c3", bus.rsp_err, 0);
        bus.rsp_ready = 1'b1;
        cycle();
        bus.rsp_ready = 1'b0;

        // ---- write from requester 1 with split handshakes ----
        bus.ram_addr_ready = 1'b0; bus.ram_wready = 1'b0;
        bus.req_valid = 4'b0010; bus.req_we = 4'b0010;
        bus.req_addr[1*ADDR_WIDTH +: ADDR_WIDTH] = 32'h3000;
        bus.req_wdata[1*BUS_WIDTH +: BUS_WIDTH]  = 64'h55;
        #1 chk("write req_ready c0", bus.req_ready, 4'b0010);
        cycle();
        bus.req_valid = '0;
        bus.ram_addr_ready = 1'b1;
        chk("write ram_wdata c1", bus.ram_wdata, 64'h55);
        chk("write ram_we c1", bus.ram_we, 1);
        cycle();
        bus.ram_addr_ready = 1'b0;
        chk("write ram_addr_valid c2", bus.ram_addr_valid, 0);
        chk("write ram_wvalid c2", bus.ram_wvalid, 1);
        cycle();
        bus.ram_wready = 1'b1;
        cycle();
        bus.ram_wready = 1'b0;
        chk("write ram_wvalid c4", bus.ram_wvalid, 0);
        chk("write rsp_valid c4", bus.rsp_valid, 1);
        chk("write rsp_id c4", bus.rsp_id, 1);
        chk("write rsp_err c4", bus.rsp_err, 0);
        bus.rsp_ready = 1'b1;
        cycle();
        bus.rsp_ready = 1'b0;
        bus.req_we = '0;

        // ---- timeout on a read from requester 3, then response backpressure ----
        bus.req_valid = 4'b1000;
        bus.req_addr[3*ADDR_WIDTH +: ADDR_WIDTH] = 32'h4000;
        cycle();
        bus.req_valid = 4'b0111;
        for (int i = 0; i < TIMEOUT; i++) begin
            chk("timeout ram_addr_valid held", bus.ram_addr_valid, 1);
            cycle();
        end
        chk("timeout ram_addr_valid", bus.ram_addr_valid, 0);
        chk("timeout rsp_valid", bus.rsp_valid, 1);
        chk("timeout rsp_err", bus.rsp_err, 1);
        chk("timeout rsp_rdata", bus.rsp_rdata, 0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall req_ready", bus.req_ready, 0);
            chk("stall rsp_valid", bus.rsp_valid, 1);
            chk("stall rsp_id", bus.rsp_id, 3);
            chk("stall rsp_err", bus.rsp_err, 1);
            chk("stall rsp_rdata", bus.rsp_rdata, 0);
            cycle();
        end
        bus.rsp_ready = 1'b1;
        cycle();
        bus.rsp_ready = 1'b0;
        #1 chk("idle after rsp req_ready", bus.req_ready, 4'b0001);
        chk("idle after rsp rsp_valid", bus.rsp_valid, 0);
        cycle();
        // drain the transaction just granted; early rvalid must be ignored
        bus.req_valid = '0;
        bus.ram_addr_ready = 1'b1; bus.ram_rvalid = 1'b1;
        bus.ram_rdata = 64'h1234_5678_9ABC_DEF0; bus.rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle();

        // ---- reset in the middle of a read ----
        bus.ram_rvalid = 1'b0; bus.rsp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++)
            bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = 32'h1000 + 32'(i);
        bus.req_valid = 4'b1111;
        cycle();
        cycle();
        chk("midread ram_rready", bus.ram_rready, 1);
        rst = 1'b1;
        cycle();
        chk("rst req_ready", bus.req_ready, 0);
        chk("rst rsp_valid", bus.rsp_valid, 0);
        chk("rst rsp_id", bus.rsp_id, 0);
        chk("rst rsp_rdata", bus.rsp_rdata, 0);
        chk("rst rsp_err", bus.rsp_err, 0);
        chk("rst ram_addr_valid", bus.ram_addr_valid, 0);
        chk("rst ram_addr", bus.ram_addr, 0);
        chk("rst ram_we", bus.ram_we, 0);
        chk("rst ram_wvalid", bus.ram_wvalid, 0);
        chk("rst ram_wdata", bus.ram_wdata, 0);
        chk("rst ram_rready", bus.ram_rready, 0);
        rst = 1'b0;

        // ---- round robin with all four requesting continuously ----
        bus.ram_addr_ready = 1'b1; bus.ram_wready = 1'b1;
        bus.ram_rvalid = 1'b1; bus.rsp_ready = 1'b1;
        #1 chk("post-reset grant", bus.req_ready, 4'b0001);
        for (int c = 0; c < 60 && grants.size() < 6; c++) begin
            #1;
            if (bus.req_ready != '0) begin
                widx = -1;
                for (int b = 0; b < NUM_REQ; b++) if (bus.req_ready[b]) widx = b;
                grants.push_back(widx);
            end
            cycle();
        end
        chk("rr grant count", grants.size(), 6);
        if (grants.size() == 6) begin
            chk("rr grant 0", grants[0], 0);
            chk("rr grant 1", grants[1], 1);
            chk("rr grant 2", grants[2], 2);
            chk("rr grant 3", grants[3], 3);
            chk("rr grant 4", grants[4], 0);
            chk("rr grant 5", grants[5], 1);
            for (int s = 0; s + 3 < 6; s++) begin
                seen = 0;
                for (int j = s; j < s + 4; j++) seen |= (1 << grants[j]);
                chk("rr window distinct", seen, 32'hF);
            end
        end

        // ---- randomized traffic against the model ----
        for (int c = 0; c < 3000; c++) begin
            bus.req_valid = 4'($urandom);
            bus.req_we    = 4'($urandom);
            for (int i = 0; i < NUM_REQ; i++) begin
                bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = $urandom;
                bus.req_wdata[i*BUS_WIDTH +: BUS_WIDTH]  = {$urandom, $urandom};
            end
            bus.ram_addr_ready = ($urandom_range(0, 99) < 35);
            bus.ram_wready     = ($urandom_range(0, 99) < 50);
            bus.ram_rvalid     = ($urandom_range(0, 99) < 30);
            bus.ram_rdata      = {$urandom, $urandom};
            bus.rsp_ready      = ($urandom_range(0, 99) < 60);
            rst                = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
